alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one ALU instance between two requesters. Accepts ALU commands over valid/ready,
//  arbitrates round-robin, drives the ALU control/operand inputs for one enabled cycle,
//  and captures the registered ALU result. It returns the result over a single response
//  channel tagged with the requester id. Sits between the requester logic and the ALU.
// PARAMETERS
//  DATA_WIDTH  5   operand width; result width is DATA_WIDTH+1 (signed), matching the ALU
//  CNT_WIDTH   16  width of the completed-operation counter
// PORTS
//  clk        input   1              system clock, rising edge
//  rst        input   1              asynchronous reset, active-high
//  req_valid  input   2              per-requester command valid (bit g = requester g)
//  req_ready  output  2              per-requester accept; one-hot, at most one bit set
//  req_mode   input   2*2            per requester: 0=A-set,1=B-set1,2=B-set2,3=reserved
//  req_op     input   2*3            per requester opcode; B modes use op[1:0]
//  req_a      input   2*DATA_WIDTH   per requester operand A (signed)
//  req_b      input   2*DATA_WIDTH   per requester operand B (signed)
//  rsp_valid  output  1              response valid
//  rsp_ready  input   1              response accept
//  rsp_id     output  1              requester that issued the command
//  rsp_data   output  DATA_WIDTH+1   signed ALU result
//  rsp_err    output  1              1 = reserved mode, no ALU operation performed
//  alu_a      output  DATA_WIDTH     to ALU A
//  alu_b      output  DATA_WIDTH     to ALU B
//  alu_a_op   output  3              to ALU a_op
//  alu_b_op   output  2              to ALU b_op
//  alu_a_en   output  1              to ALU a_en
//  alu_b_en   output  1              to ALU b_en
//  alu_en     output  1              to ALU ALU_en
//  alu_c      input   DATA_WIDTH+1   from ALU C (registered inside ALU)
//  ops_done   output  CNT_WIDTH      count of completed response handshakes, wraps
// BEHAVIOUR
//  - Top level drives ALU rst_n = ~rst; both blocks reset together.
//  - Reset: FSM=IDLE, all outputs 0, rr priority = requester 0, ops_done = 0.
//  - All outputs are registered. FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: if any req_valid is set, grant g = prioritised requester if valid, else the other.
//    Assert req_ready[g] for exactly this cycle (handshake = valid&ready). Latch mode, op, A,
//    B and id=g. Set rr priority to 1-g. Go to ISSUE. req_ready is 0 in every other state.
//  - ISSUE (1 cycle): alu_en=1 with alu_a/alu_b = latched operands.
//    Mode 0: a_en=1, b_en=0, a_op=op. Mode 1: a_en=0, b_en=1, b_op=op[1:0].
//    Mode 2: a_en=1, b_en=1, b_op=op[1:0]. Mode 3: alu_en=0 and ALU untouched.
//  - Outside ISSUE: alu_en=a_en=b_en=0, ops=0, alu_a/alu_b hold their last values.
//  - WAIT (1 cycle): alu_c now holds the result. Register rsp_data=alu_c and rsp_err=0.
//    For mode 3, rsp_data=0 and rsp_err=1. Go to RESP.
//  - RESP: rsp_valid=1; rsp_id/rsp_data/rsp_err stable until rsp_valid&rsp_ready.
//    On that handshake: rsp_valid=0, ops_done+1 (wraps at 2^CNT_WIDTH), go to IDLE.
//  - Latency: accept at cycle T, ALU enabled at T+1, rsp_valid first high at T+3.
//    Throughput is at most 1 command per 4 cycles (rsp_ready held high).
//  - ALU null ops (A-set op 7, B-set1 op 3) return the ALU's held previous value, rsp_err=0.
//  - A request arriving while not IDLE waits; the requester must hold valid and payload.
//  - rst asserted mid-operation: immediate return to reset state. The in-flight command and
//    response are dropped, and no ops_done increment occurs.
// TESTING
//  - Reset: assert rst mid-RESP -> rsp_valid=0, req_ready=0, alu_en=0, ops_done=0 same cycle.
//  - Req0 mode0 op0 A=5 B=3, rsp_ready=1 -> accept T, alu_en@T+1, rsp_valid@T+3 data=8 id=0.
//  - Both valid continuously, 4 cmds each -> grants 0,1,0,1,... and ops_done=8 at the end.
//  - Mode2 op2 A=-16 -> rsp_data=-17; mode1 op0 A=5 B=3 -> rsp_data=30 ({0,~(5&3)}).
//  - rsp_ready=0 for 5 cycles in RESP -> rsp_data/id stable, req_ready stays 0, no new grant.
//  - Mode3 from req1 -> alu_en never 1, rsp_err=1, rsp_data=0, id=1; ops_done increments.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters with round-robin arbitration.
// Commands arrive over valid/ready; results return on one response channel tagged with the id.
module alu_arbiter #(
    parameter int DATA_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [3:0]              req_mode,
    input  logic [5:0]              req_op,
    input  logic [2*DATA_WIDTH-1:0] req_a,
    input  logic [2*DATA_WIDTH-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [DATA_WIDTH:0]     rsp_data,
    output logic                    rsp_err,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [2:0]              alu_a_op,
    output logic [1:0]              alu_b_op,
    output logic                    alu_a_en,
    output logic                    alu_b_en,
    output logic                    alu_en,
    input  logic [DATA_WIDTH:0]     alu_c,
    output logic [CNT_WIDTH-1:0]    ops_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {MODE_A, MODE_B1, MODE_B2, MODE_RSVD} mode_t;

    state_t state, state_nx;
    mode_t  lat_mode, lat_mode_d, sel_mode;
    logic   prio, prio_nx;
    logic   lat_id, lat_id_d;
    logic   req_hs, rsp_hs, gnt, pick;

    logic [2:0]            sel_op;
    logic [DATA_WIDTH-1:0] sel_a, sel_b;

    logic [1:0]            req_ready_d;
    logic                  rsp_valid_d, rsp_id_d, rsp_err_d;
    logic [DATA_WIDTH:0]   rsp_data_d;
    logic [DATA_WIDTH-1:0] alu_a_d, alu_b_d;
    logic [2:0]            alu_a_op_d;
    logic [1:0]            alu_b_op_d;
    logic                  alu_a_en_d, alu_b_en_d, alu_en_d;
    logic [CNT_WIDTH-1:0]  ops_done_d;

    // req_ready is one-hot, so its upper bit names the granted requester.
    assign gnt    = req_ready[1];
    assign req_hs = (state == IDLE) && |(req_valid & req_ready);
    assign rsp_hs = rsp_valid & rsp_ready;

    assign sel_mode = mode_t'(gnt ? req_mode[3:2] : req_mode[1:0]);
    assign sel_op   = gnt ? req_op[5:3] : req_op[2:0];
    assign sel_a    = gnt ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
    assign sel_b    = gnt ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            lat_id    <= 1'b0;
            lat_mode  <= MODE_A;
            req_ready <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_a_op  <= '0;
            alu_b_op  <= '0;
            alu_a_en  <= 1'b0;
            alu_b_en  <= 1'b0;
            alu_en    <= 1'b0;
            ops_done  <= '0;
        end else begin
            state     <= state_nx;
            prio      <= prio_nx;
            lat_id    <= lat_id_d;
            lat_mode  <= lat_mode_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_a_op  <= alu_a_op_d;
            alu_b_op  <= alu_b_op_d;
            alu_a_en  <= alu_a_en_d;
            alu_b_en  <= alu_b_en_d;
            alu_en    <= alu_en_d;
            ops_done  <= ops_done_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_hs) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = RESP;
            RESP:    if (rsp_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered, so the grant offered in the next IDLE cycle is
    // decided now from the next state and the already-updated priority.
    always_comb begin
        prio_nx     = req_hs ? ~gnt : prio;
        pick        = req_valid[prio_nx] ? prio_nx : ~prio_nx;
        req_ready_d = '0;
        if (state_nx == IDLE && |req_valid)
            req_ready_d = pick ? 2'b10 : 2'b01;

        lat_id_d   = lat_id;
        lat_mode_d = lat_mode;
        alu_a_d    = alu_a;
        alu_b_d    = alu_b;
        alu_a_op_d = '0;
        alu_b_op_d = '0;
        alu_a_en_d = 1'b0;
        alu_b_en_d = 1'b0;
        alu_en_d   = 1'b0;
        if (req_hs) begin
            lat_id_d   = gnt;
            lat_mode_d = sel_mode;
            if (sel_mode != MODE_RSVD) begin
                alu_en_d = 1'b1;
                alu_a_d  = sel_a;
                alu_b_d  = sel_b;
                case (sel_mode)
                    MODE_A: begin
                        alu_a_en_d = 1'b1;
                        alu_a_op_d = sel_op;
                    end
                    MODE_B1: begin
                        alu_b_en_d = 1'b1;
                        alu_b_op_d = sel_op[1:0];
                    end
                    default: begin
                        alu_a_en_d = 1'b1;
                        alu_b_en_d = 1'b1;
                        alu_b_op_d = sel_op[1:0];
                    end
                endcase
            end
        end

        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        if (state == WAIT) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = lat_id;
            if (lat_mode == MODE_RSVD) begin
                rsp_data_d = '0;
                rsp_err_d  = 1'b1;
            end else begin
                rsp_data_d = alu_c;
                rsp_err_d  = 1'b0;
            end
        end
        if (rsp_hs)
            rsp_valid_d = 1'b0;

        ops_done_d = ops_done + CNT_WIDTH'(rsp_hs);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stand-in, directed vector table, multi-cycle
// sequences and a randomized run scored against an arithmetic reference model.
module tb_alu_arbiter;

    localparam int DW = 5;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_ready;
    logic [3:0]      req_mode;
    logic [5:0]      req_op;
    logic [2*DW-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [DW:0]     rsp_data;
    logic [DW-1:0]   alu_a, alu_b;
    logic [2:0]      alu_a_op;
    logic [1:0]      alu_b_op;
    logic            alu_a_en, alu_b_en, alu_en;
    logic [DW:0]     alu_c;
    logic [CW-1:0]   ops_done;
    logic            alu_rst_n;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_a_op(alu_a_op), .alu_b_op(alu_b_op),
        .alu_a_en(alu_a_en), .alu_b_en(alu_b_en), .alu_en(alu_en),
        .alu_c(alu_c), .ops_done(ops_done)
    );

    // ALU operation sets, written as plain signed arithmetic on the operands.
    function automatic logic [DW:0] a_set(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW:0] prev);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: r = sa & sb;
            3'd3: r = sa | sb;
            3'd4: r = sa ^ sb;
            3'd5: r = ~sa;
            3'd6: r = sa >>> 1;
            default: return prev;
        endcase
        return r[DW:0];
    endfunction

    function automatic logic [DW:0] b_set1(input logic [1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [DW:0] prev);
        case (op)
            2'd0: return {1'b0, ~(a & b)};
            2'd1: return {1'b0, ~(a | b)};
            2'd2: return {1'b0, ~(a ^ b)};
            default: return prev;
        endcase
    endfunction

    function automatic logic [DW:0] b_set2(input logic [1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0: r = sa + 1;
            2'd1: r = sb + 1;
            2'd2: r = sa - 1;
            default: r = sb - 1;
        endcase
        return r[DW:0];
    endfunction

    assign alu_rst_n = ~rst;

    always_ff @(posedge clk or negedge alu_rst_n) begin
        if (!alu_rst_n) alu_c <= '0;
        else if (alu_en) begin
            case ({alu_a_en, alu_b_en})
                2'b10:   alu_c <= a_set(alu_a_op, alu_a, alu_b, alu_c);
                2'b01:   alu_c <= b_set1(alu_b_op, alu_a, alu_b, alu_c);
                2'b11:   alu_c <= b_set2(alu_b_op, alu_a, alu_b);
                default: alu_c <= alu_c;
            endcase
        end
    end

    typedef struct {logic [1:0] mode; logic [2:0] op; logic [DW-1:0] a; logic [DW-1:0] b;} cmd_t;
    typedef struct {logic id; logic [DW:0] data; logic err;} rsp_t;
    typedef struct {
        logic id; logic [1:0] mode; logic [2:0] op; logic [DW-1:0] a; logic [DW-1:0] b;
        logic [DW:0] exp_data; logic exp_err;
    } vec_t;

    int          n_vec = 0;
    int          n_miss = 0;
    int          n_rsp = 0;
    int          exp_ops = 0;
    cmd_t        pend[2][$];
    rsp_t        expq[$];
    int          grants[$];
    logic [DW:0] model_c;
    logic [1:0]  drop;
    logic [1:0]  hs_req_l;
    logic        hs_rsp_l;
    rsp_t        last_rsp;
    bit          rand_gap, rsp_rand, alu_en_seen;
    logic        rsp_rdy_force;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: one command at a time through the shared ALU, whose last result
    // is what null ops return; reserved mode leaves that result untouched.
    task automatic model_cmd(input cmd_t c, output logic [DW:0] d, output logic er);
        er = 1'b0;
        case (c.mode)
            2'd0: d = a_set(c.op, c.a, c.b, model_c);
            2'd1: d = b_set1(c.op[1:0], c.a, c.b, model_c);
            2'd2: d = b_set2(c.op[1:0], c.a, c.b);
            default: begin
                d  = '0;
                er = 1'b1;
            end
        endcase
        if (!er) model_c = d;
    endtask

    task automatic cycle();
        rsp_t        e, r;
        cmd_t        c;
        logic [DW:0] d;
        logic        er;
        @(negedge clk);
        if (alu_en === 1'b1) alu_en_seen = 1'b1;
        chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
        for (int g = 0; g < 2; g++)
            if (drop[g]) begin
                req_valid[g] = 1'b0;
                drop[g] = 1'b0;
            end
        for (int g = 0; g < 2; g++)
            if (!req_valid[g] && pend[g].size() > 0 && (!rand_gap || $urandom_range(1) == 1)) begin
                req_mode[g*2 +: 2] = pend[g][0].mode;
                req_op[g*3 +: 3]   = pend[g][0].op;
                req_a[g*DW +: DW]  = pend[g][0].a;
                req_b[g*DW +: DW]  = pend[g][0].b;
                req_valid[g]       = 1'b1;
            end
        rsp_ready = rsp_rand ? ($urandom_range(3) != 0) : rsp_rdy_force;
        hs_req_l = req_valid & req_ready;
        hs_rsp_l = rsp_valid & rsp_ready;
        if (hs_rsp_l) begin
            last_rsp = '{rsp_id, rsp_data, rsp_err};
            n_rsp++;
            exp_ops++;
            if (expq.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rsp_unexpected: got id %0d data %0d, required no response", rsp_id, rsp_data);
            end else begin
                e = expq.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", rsp_err, e.err);
            end
        end
        for (int g = 0; g < 2; g++)
            if (hs_req_l[g] && pend[g].size() > 0) begin
                c = pend[g].pop_front();
                model_cmd(c, d, er);
                r.id = g[0];
                r.data = d;
                r.err = er;
                expq.push_back(r);
                grants.push_back(g);
                drop[g] = 1'b1;
            end
    endtask

    task automatic run_until_rsp(input string name, input int budget);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!hs_rsp_l && k < budget);
        if (!hs_rsp_l) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: got no response, required one within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_rsp_valid(input string name, input int budget);
        int k;
        k = 0;
        while (rsp_valid !== 1'b1 && k < budget) begin
            cycle();
            k++;
        end
        if (rsp_valid !== 1'b1) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: got rsp_valid=0, required 1 within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[12];
        cmd_t c;
        int   k, target;

        vt[0]  = '{1'b0, 2'd0, 3'd0, 5'd5,      5'd3,      6'd8,       1'b0};
        vt[1]  = '{1'b1, 2'd2, 3'd2, 5'b10000,  5'd0,      6'b101111,  1'b0};
        vt[2]  = '{1'b0, 2'd1, 3'd0, 5'd5,      5'd3,      6'd30,      1'b0};
        vt[3]  = '{1'b1, 2'd3, 3'd0, 5'd7,      5'd7,      6'd0,       1'b1};
        vt[4]  = '{1'b0, 2'd0, 3'd7, 5'd1,      5'd1,      6'd30,      1'b0};
        vt[5]  = '{1'b1, 2'd1, 3'd3, 5'd2,      5'd2,      6'd30,      1'b0};
        vt[6]  = '{1'b0, 2'd0, 3'd1, 5'd3,      5'd5,      6'b111110,  1'b0};
        vt[7]  = '{1'b1, 2'd0, 3'd0, 5'b10000,  5'b10000,  6'b100000,  1'b0};
        vt[8]  = '{1'b0, 2'd2, 3'd1, 5'd0,      5'd15,     6'd16,      1'b0};
        vt[9]  = '{1'b1, 2'd2, 3'd3, 5'd0,      5'b10000,  6'b101111,  1'b0};
        vt[10] = '{1'b0, 2'd1, 3'd1, 5'd5,      5'd3,      6'd24,      1'b0};
        vt[11] = '{1'b1, 2'd0, 3'd4, 5'd5,      5'd3,      6'd6,       1'b0};

        rst = 1'b1;
        req_valid = '0; req_mode = '0; req_op = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b0; rsp_rdy_force = 1'b1; rand_gap = 0; rsp_rand = 0;
        drop = '0; model_c = '0; alu_en_seen = 0; hs_req_l = '0; hs_rsp_l = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_alu_en", alu_en, 0);
        chk("reset_ops_done", ops_done, 0);
        chk("reset_rsp_data", rsp_data, 0);
        rst = 1'b0;

        // Accept at T, ALU enabled at T+1, response at T+3.
        pend[0].push_back('{2'd0, 3'd0, 5'd5, 5'd3});
        k = 0;
        do begin cycle(); k++; end while (!hs_req_l[0] && k < 10);
        chk("lat_accept", hs_req_l, 2'b01);
        cycle();
        chk("lat_alu_en_t1", alu_en, 1);
        chk("lat_alu_a", alu_a, 5);
        chk("lat_alu_b", alu_b, 3);
        chk("lat_a_en", alu_a_en, 1);
        chk("lat_b_en", alu_b_en, 0);
        cycle();
        chk("lat_alu_en_t2", alu_en, 0);
        chk("lat_rsp_t2", rsp_valid, 0);
        cycle();
        chk("lat_rsp_t3", rsp_valid, 1);
        chk("lat_data", rsp_data, 8);
        chk("lat_id", rsp_id, 0);
        cycle();
        chk("lat_ops_done", ops_done, 1);

        for (int i = 0; i < 12; i++) begin
            alu_en_seen = 0;
            pend[int'(vt[i].id)].push_back('{vt[i].mode, vt[i].op, vt[i].a, vt[i].b});
            run_until_rsp("vec_timeout", 20);
            if (hs_rsp_l) begin
                chk("vec_id", last_rsp.id, vt[i].id);
                chk("vec_data", last_rsp.data, vt[i].exp_data);
                chk("vec_err", last_rsp.err, vt[i].exp_err);
                chk("vec_alu_en", alu_en_seen, vt[i].mode != 2'd3);
            end
            cycle();
            chk("vec_ops_done", ops_done, exp_ops);
        end

        // Response back-pressure: outputs hold and no new grant is offered.
        rsp_rdy_force = 1'b0;
        pend[0].push_back('{2'd0, 3'd0, 5'd1, 5'd2});
        wait_rsp_valid("stall_wait", 10);
        pend[1].push_back('{2'd0, 3'd1, 5'd4, 5'd1});
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, 3);
            chk("stall_id", rsp_id, 0);
            chk("stall_ready", req_ready, 0);
        end
        rsp_rdy_force = 1'b1;
        run_until_rsp("stall_release", 5);
        run_until_rsp("stall_next", 10);
        if (hs_rsp_l) chk("stall_next_id", last_rsp.id, 1);

        // Reset while a response is pending.
        rsp_rdy_force = 1'b0;
        pend[1].push_back('{2'd0, 3'd0, 5'd1, 5'd1});
        wait_rsp_valid("rstmid_wait", 10);
        rst = 1'b1;
        #1;
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_req_ready", req_ready, 0);
        chk("rstmid_alu_en", alu_en, 0);
        chk("rstmid_ops_done", ops_done, 0);
        expq.delete(); pend[0].delete(); pend[1].delete(); grants.delete();
        req_valid = '0; drop = '0; model_c = '0; exp_ops = 0;
        @(negedge clk);
        rst = 1'b0;
        rsp_rdy_force = 1'b1;

        // Both requesters continuously valid: grants must alternate from requester 0.
        for (int i = 0; i < 4; i++)
            for (int g = 0; g < 2; g++) begin
                c.mode = 2'($urandom_range(2)); c.op = 3'($urandom_range(7));
                c.a = DW'($urandom); c.b = DW'($urandom);
                pend[g].push_back(c);
            end
        target = n_rsp + 8;
        k = 0;
        while (n_rsp < target && k < 100) begin cycle(); k++; end
        cycle();
        chk("rr_count", grants.size(), 8);
        for (int i = 0; i < 8 && i < grants.size(); i++) chk("rr_grant", grants[i], i % 2);
        chk("rr_ops_done", ops_done, 8);

        // Randomized traffic with gaps and random response back-pressure.
        rand_gap = 1; rsp_rand = 1;
        for (int i = 0; i < 60; i++)
            for (int g = 0; g < 2; g++) begin
                c.mode = 2'($urandom_range(3)); c.op = 3'($urandom_range(7));
                c.a = DW'($urandom); c.b = DW'($urandom);
                pend[g].push_back(c);
            end
        target = n_rsp + 120;
        k = 0;
        while (n_rsp < target && k < 3000) begin cycle(); k++; end
        rsp_rand = 0;
        cycle();
        chk("rand_responses", n_rsp, target);
        chk("rand_drain", expq.size(), 0);
        chk("rand_ops_done", ops_done, 32'(exp_ops[CW-1:0]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
